// File: rtl/pipe_defs.sv
// Pipeline-wide definitions shared by the decode, memory and write-back stages:
// load/store one-hot bit positions and the reset PC.
package pipe_defs;

  localparam int LD_LB  = 0;
  localparam int LD_LBU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 4;
  localparam int ST_SB  = 5;
  localparam int ST_SH  = 6;
  localparam int ST_SW  = 7;

  localparam logic [31:0] PIPE_RESET_PC = 32'h1c000000;

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
    return {{24{sgn & v[7]}}, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    return {{16{sgn & v[15]}}, v};
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data alignment: picks the addressed byte/half/word out of
// the SRAM word and sign- or zero-extends it. Store bits of load_op are ignored.
module load_align
  import pipe_defs::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  off,
  input  logic [7:0]  load_op,
  output logic [31:0] aligned
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_store_bits;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rd[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[off];
  // Misaligned halves fault upstream, so only off[1] picks the half.
  assign half_sel = off[1] ? rd[31:16] : rd[15:0];
  assign unused_store_bits = ^load_op[7:5];

  always_comb begin
    aligned = '0;
    if (load_op[LD_LB])       aligned = ext8(byte_sel, 1'b1);
    else if (load_op[LD_LBU]) aligned = ext8(byte_sel, 1'b0);
    else if (load_op[LD_LH])  aligned = ext16(half_sel, 1'b1);
    else if (load_op[LD_LHU]) aligned = ext16(half_sel, 1'b0);
    else if (load_op[LD_LW])  aligned = rd;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: load alignment, register-file write, ID bypass/hazard info,
// debug trace and retire counter. Define WB_TRACE_STALL_EN to honour debug_ready.
module wb_stage
  import pipe_defs::*;
#(
  parameter logic [31:0] RESET_PC = PIPE_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] result,
  input  logic [31:0] PC,
  input  logic [7:0]  load_op,
  input  logic        res_from_mem,
  input  logic        gr_we,
  input  logic [4:0]  dest,
  input  logic [31:0] data_sram_rdata,
  input  logic        debug_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_fwd_data,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic [31:0] retire_cnt
);

  logic        ready_go;
  logic        ret;
  logic [31:0] rd;
  logic [31:0] aligned;
  logic [31:0] last_pc_reg;

`ifdef WB_TRACE_STALL_EN
  logic        held_reg;
  logic [31:0] rdata_reg;

  assign ready_go = debug_ready;

  // SRAM data is only valid in the first cycle here; keep it across a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_reg  <= 1'b0;
      rdata_reg <= '0;
    end else if (ret) begin
      held_reg  <= 1'b0;
    end else if (in_valid && !held_reg) begin
      held_reg  <= 1'b1;
      rdata_reg <= data_sram_rdata;
    end
  end

  assign rd = held_reg ? rdata_reg : data_sram_rdata;
`else
  logic unused_debug_ready;

  assign ready_go           = 1'b1;
  assign unused_debug_ready = debug_ready;
  assign rd                 = data_sram_rdata;
`endif

  assign in_ready = ~rst & (~in_valid | ready_go);
  assign ret      = in_valid & ready_go & ~rst;

  load_align u_load_align (
    .rd      (rd),
    .off     (result[1:0]),
    .load_op (load_op),
    .aligned (aligned)
  );

  assign rf_wdata    = res_from_mem ? aligned : result;
  assign rf_we       = gr_we & ret;
  assign rf_waddr    = dest;
  assign wb_fwd_data = rf_wdata;
  // Held while stalled so ID keeps interlocking on this destination.
  assign wb_dest     = (in_valid & gr_we) ? dest : 5'd0;

  assign debug_wb_pc       = in_valid ? PC : last_pc_reg;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = dest;
  assign debug_wb_rf_wdata = rf_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc_reg <= RESET_PC;
      retire_cnt  <= '0;
    end else if (ret) begin
      last_pc_reg <= PC;
      retire_cnt  <= retire_cnt + 32'd1;
    end
  end

endmodule
